uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of one FIFO entry.
REQ-002 Parameter DEPTH, default 8, number of entries; the block SHALL support only powers of two from 2 to 16.
REQ-003 Parameter ADDR_W, default 3, pointer width, equal to log2(DEPTH).
REQ-004 clk_tx  input  1  transmit-side clock; every port is synchronous to it.
REQ-005 rst_n  input  1  reset: synchronous, active-low.
REQ-006 wr_en  input  1  CPU SBUF write strobe, one byte per cycle while high.
REQ-007 wr_data  input  DATA_W  byte to enqueue.
REQ-008 full  output  1  high when count equals DEPTH.
REQ-009 rd_en  input  1  pop request from the UART serializer read-enable.
REQ-010 rd_data  output  DATA_W  head entry, first-word-fall-through.
REQ-011 empty  output  1  high when count equals 0; drives the serializer fifo_empty input.
REQ-012 count  output  ADDR_W+1  number of stored entries.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  clears ovf.
REQ-015 tx_int  output  1  transmit-done interrupt flag (TI).
REQ-016 tx_int_clr  input  1  software acknowledge of tx_int.

Function
REQ-017 The storage array SHALL be written at wr_ptr on a clock edge when wr_en is high and the write is accepted.
REQ-018 rd_data SHALL combinationally equal mem[rd_ptr] when empty is 0, and 8'h00 when empty is 1, so the serializer samples the byte in the same cycle it asserts rd_en.
REQ-019 A write SHALL be accepted when full is 0, or when full is 1 and rd_en is 1 in the same cycle.
REQ-020 A read SHALL be accepted only when empty is 0.
REQ-021 On a rejected write the data SHALL be discarded, the pointers SHALL be unchanged, and ovf SHALL be set on the next edge.
REQ-022 A rejected read (rd_en while empty) SHALL have no effect on state and SHALL NOT raise any flag.
REQ-023 There SHALL be no write-to-read bypass: a simultaneous wr_en and rd_en while empty SHALL accept only the write, leaving count at 1 and the old rd_data at 8'h00 for that cycle.
REQ-024 Simultaneous accepted read and write SHALL leave count unchanged and advance both pointers.
REQ-025 Pointers SHALL increment modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-026 count SHALL be a register updated by +1, -1 or 0, and full and empty SHALL be decoded from count, with no extra latency.
REQ-027 Write-to-visible latency SHALL be 1 cycle: a byte written into an empty FIFO at edge N SHALL appear on rd_data, with empty=0, after edge N.
REQ-028 tx_int control SHALL be a 3-state FSM:
- IDLE (empty, no pending data)
- SENDING (count>0)
- DONE (tx_int=1)
REQ-029 IDLE SHALL go to SENDING on any accepted write.
REQ-030 SENDING SHALL go to DONE when an accepted read takes count from 1 to 0 with no simultaneous write.
REQ-031 DONE SHALL go to IDLE on tx_int_clr, or to SENDING on an accepted write; the flag SHALL remain 1 in DONE until tx_int_clr regardless of writes.
REQ-032 tx_int SHALL be registered, set on entry to DONE, and cleared only by tx_int_clr.
REQ-033 If the set condition and tx_int_clr coincide, set SHALL win.
REQ-034 If ovf_clr and a new overflow coincide, ovf SHALL remain 1.

Reset
REQ-035 While rst_n is low at an edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovf=0, tx_int=0 and FSM=IDLE.
REQ-036 The storage array SHALL NOT be reset.
REQ-037 Reset asserted mid-operation SHALL discard all queued bytes, and rd_data SHALL read 8'h00 on the next cycle.
REQ-038 wr_en and rd_en SHALL be ignored in any cycle in which rst_n is low.

Structure
REQ-039 DATA_W, DEPTH, ADDR_W defaults and the FSM state encoding (IDLE=2'd0, SENDING=2'd1, DONE=2'd2) SHALL live in the shared package uart_pkg.
REQ-040 The storage array SHALL be one sub-module, uart_fifo_mem: single write port, asynchronous read port, no reset.
REQ-041 Pointer, count and FSM logic SHALL reside in uart_tx_fifo.

Verification
REQ-042 Reset, then write 8'hA5 -> next cycle empty=0, count=1, rd_data=8'hA5; pulse rd_en -> empty=1, count=0, tx_int=1 on the following cycle.
REQ-043 Write 8 bytes 8'h01..8'h08 -> full=1, count=8; 9th write 8'hFF -> ovf=1, contents unchanged; 8 reads return 8'h01..8'h08 in order.
REQ-044 Fill to full, then simultaneous wr_en(8'h55)+rd_en -> count stays 8, no ovf, and 8'h55 emerges as the 8th subsequent read (exercises pointer wrap).
REQ-045 Empty FIFO, simultaneous wr_en(8'h3C)+rd_en -> count=1, rd_data=8'h3C next cycle, tx_int stays 0.
REQ-046 tx_int=1, then assert tx_int_clr in the same cycle as a last-byte read -> tx_int remains 1; a later tx_int_clr alone -> tx_int=0.
REQ-047 Assert rst_n=0 with count=5 -> next cycle count=0, empty=1, ovf=0, tx_int=0, rd_data=8'h00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: default geometry and the
// encoding of the transmit-done interrupt state machine.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int UART_DEPTH  = 8;
   localparam int UART_ADDR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SENDING = 2'd1,
      ST_DONE    = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_DEPTH,
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic              clk_tx,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Store one entry per accepted write.
   always_ff @(posedge clk_tx) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: first-word-fall-through queue between the CPU SBUF
// writes and the serializer, with sticky overflow and a transmit-done flag.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_DEPTH,
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic              clk_tx,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              ovf,
   input  logic              ovf_clr,
   output logic              tx_int,
   input  logic              tx_int_clr
);

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || (1 << ADDR_W) != DEPTH) begin : g_bad_param
      $error("uart_tx_fifo: DEPTH must be a power of two in 2..16 and equal 2**ADDR_W");
   end

   localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1'b1);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              ovf_r;
   logic              tx_int_r;
   tx_state_e         state_r;

   logic              full_s;
   logic              empty_s;
   logic              wr_acc_s;
   logic              rd_acc_s;
   logic              last_rd_s;
   logic              mem_we_s;
   logic [DATA_W-1:0] mem_rd_s;
   logic [DATA_W-1:0] rd_data_s;

   // Status decode and write/read acceptance; a full FIFO still takes a write
   // when the serializer pops in the same cycle.
   always_comb begin
      full_s    = (count_r == CNT_FULL);
      empty_s   = (count_r == CNT_ZERO);
      rd_acc_s  = rd_en && !empty_s;
      wr_acc_s  = wr_en && (!full_s || rd_en);
      last_rd_s = rd_acc_s && !wr_acc_s && (count_r == CNT_ONE);
      mem_we_s  = wr_acc_s && rst_n;
      if (empty_s) begin
         rd_data_s = DATA_ZERO;
      end else begin
         rd_data_s = mem_rd_s;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_tx (clk_tx),
      .we     (mem_we_s),
      .waddr  (wr_ptr_r),
      .wdata  (wr_data),
      .raddr  (rd_ptr_r),
      .rdata  (mem_rd_s)
   );

   // Pointers, occupancy count and sticky overflow.
   always_ff @(posedge clk_tx) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         ovf_r    <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
         if (wr_en && !wr_acc_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Transmit-done state machine; the flag survives new writes until acknowledged.
   always_ff @(posedge clk_tx) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         tx_int_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (wr_acc_s) begin
                  state_r <= ST_SENDING;
               end
            end
            ST_SENDING: begin
               if (last_rd_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (wr_acc_s) begin
                  state_r <= ST_SENDING;
               end else if (tx_int_clr) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
         if ((state_r == ST_SENDING) && last_rd_s) begin
            tx_int_r <= 1'b1;
         end else if (tx_int_clr) begin
            tx_int_r <= 1'b0;
         end
      end
   end

   assign full    = full_s;
   assign empty   = empty_s;
   assign count   = count_r;
   assign ovf     = ovf_r;
   assign tx_int  = tx_int_r;
   assign rd_data = rd_data_s;

endmodule
